multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle RISC-V control FSM. Sequences FETCH/DECODE/EXEC/MEM/WB per instruction and drives datapath control per state.
//  Adds a memory ready handshake with a bounded wait-state timeout, an illegal-opcode trap and a retired-instruction counter.
//  Sits between the instruction register and the shared-memory datapath, and replaces the single-cycle decode for the multi-cycle core.
// PARAMETERS
//  MEM_TIMEOUT  8   max cycles waiting for mem_ready in FETCH or MEM before trap; 0 = no timeout
//  WAIT_W       4   width of wait-state counter; must hold MEM_TIMEOUT-1
//  CNT_W        32  width of retired-instruction counter
// PORTS
//  clk          in   1      clock, rising edge
//  rst          in   1      synchronous reset, active-high
//  opcode       in   7      instruction opcode [6:0] from IR; sampled in DECODE only
//  zero         in   1      ALU zero flag; used in EXEC for BEQ
//  mem_ready    in   1      memory completes the current read or write this cycle
//  pc_write     out  1      PC <- next PC (PC+4 in FETCH, target in EXEC)
//  ir_write     out  1      IR <- memory read data
//  alu_op       out  2      00 add, 01 sub, 10 funct-decoded
//  alu_src      out  1      0 = rs2, 1 = immediate
//  mem_read     out  1      memory read request (instruction or load)
//  mem_write    out  1      memory write request (store)
//  mem_2_reg    out  1      writeback selects memory data
//  reg_write    out  1      register file write enable
//  branch       out  1      BEQ evaluation cycle
//  jump         out  1      JAL cycle; writeback selects PC+4
//  trap         out  1      sticky: illegal opcode or memory timeout
//  busy         out  1      1 in every state except TRAP
//  retired      out  CNT_W  instructions completed; wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset: state=FETCH, op_q=0, wait_cnt=0, retired=0, trap=0. Reset wins over every other event, including mid-MEM and TRAP.
//  Outputs not listed for a state are 0. Outputs decode combinationally from state, op_q and the inputs; state and counters are registered.
//  FETCH: mem_read=1. If mem_ready=1, assert ir_write=1 and pc_write=1 that cycle, then -> DECODE. Otherwise stay and increment wait_cnt.
//  DECODE: op_q<=opcode. R(0110011), I(0010011), LOAD(0000011), STORE(0100011), BEQ(1100011), JAL(1101111) -> EXEC. Any other opcode -> TRAP.
//  EXEC, by op_q:
//    R: alu_op=10, alu_src=0 -> WB.
//    I: alu_op=10, alu_src=1 -> WB.
//    LOAD/STORE: alu_op=00, alu_src=1 -> MEM.
//    BEQ: alu_op=01, branch=1, pc_write=zero; retire -> FETCH.
//    JAL: jump=1, pc_write=1 -> WB.
//  MEM: LOAD: mem_read=1; on mem_ready -> WB. STORE: mem_write=1; on mem_ready, retire -> FETCH. No mem_ready: stay, increment wait_cnt.
//  WB: reg_write=1; mem_2_reg=1 for LOAD; jump=1 for JAL; retire -> FETCH.
//  TRAP: trap=1, busy=0, all other controls 0. No exit except rst.
//  Wait counter: cleared on entry to FETCH or MEM.
//    Timeout when MEM_TIMEOUT!=0, mem_ready=0 and wait_cnt==MEM_TIMEOUT-1 -> TRAP next cycle, so the request is held for exactly MEM_TIMEOUT cycles.
//    mem_ready=1 in the timeout cycle counts as completion; ready wins.
//  Retire: retired+1 on the cycle the FSM leaves WB, BEQ EXEC or STORE MEM. Wraps from all-ones to 0.
//  Latency with mem_ready tied 1: R/I/JAL = 4 cycles, LOAD = 5, STORE = 4, BEQ = 3.
// TESTING
//  mem_ready=1; ADD then ADDI -> each 4 cycles F/D/E/WB, reg_write high only in WB, retired=2.
//  LOAD with mem_ready low 3 cycles in MEM -> mem_read held 4 cycles, then WB with mem_2_reg=1; total 8 cycles.
//  BEQ with zero=1 -> pc_write=1 in EXEC; zero=0 -> pc_write=0. Both give 3 cycles and retired+1.
//  opcode=7'b1111111 in DECODE -> TRAP next cycle, trap=1, busy=0, retired unchanged; rst -> FETCH, trap=0.
//  MEM_TIMEOUT=8, mem_ready stuck 0 in FETCH -> 8 cycles of mem_read, then trap=1. Ready on the 8th cycle -> DECODE, no trap.
//  CNT_W=4, 16 stores -> retired wraps to 0. rst asserted during a stalled MEM -> FETCH, outputs and retired cleared next cycle.

Source files
------------

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath bundle: IR opcode, ALU flag and memory handshake in,
// per-state datapath controls and status out. slave = control unit, master = datapath.
interface multicycle_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [6:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             pc_write;
  logic             ir_write;
  logic [1:0]       alu_op;
  logic             alu_src;
  logic             mem_read;
  logic             mem_write;
  logic             mem_2_reg;
  logic             reg_write;
  logic             branch;
  logic             jump;
  logic             trap;
  logic             busy;
  logic [CNT_W-1:0] retired;

  modport master (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, alu_op, alu_src, mem_read, mem_write,
           mem_2_reg, reg_write, branch, jump, trap, busy, retired
  );

  modport slave (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, alu_op, alu_src, mem_read, mem_write,
           mem_2_reg, reg_write, branch, jump, trap, busy, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RISC-V control FSM (FETCH/DECODE/EXEC/MEM/WB) with memory wait-state
// timeout, illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 8,
  parameter int WAIT_W      = 4,
  parameter int CNT_W       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  multicycle_control_unit_if.slave  bus
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  state_t            state, nstate;
  logic [6:0]        op_q;
  logic [WAIT_W-1:0] wait_cnt;
  logic [CNT_W-1:0]  retired;
  logic              retire, timeout;

  logic       pc_write, ir_write, alu_src, mem_read, mem_write;
  logic       mem_2_reg, reg_write, branch, jump, trap, busy;
  logic [1:0] alu_op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      op_q     <= '0;
      wait_cnt <= '0;
      retired  <= '0;
    end else begin
      state <= nstate;
      if (state == S_DECODE) op_q <= bus.opcode;
      // counts only while parked in a memory state; any transition clears it
      if ((state == S_FETCH || state == S_MEM) && nstate == state)
        wait_cnt <= wait_cnt + 1'b1;
      else
        wait_cnt <= '0;
      if (retire) retired <= retired + CNT_W'(1);
    end
  end

  always_comb begin
    nstate    = state;
    retire    = 1'b0;
    pc_write  = 1'b0;
    ir_write  = 1'b0;
    alu_op    = 2'b00;
    alu_src   = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_2_reg = 1'b0;
    reg_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    trap      = 1'b0;
    busy      = 1'b1;
    // ready in the last permitted cycle still completes the access
    timeout   = (MEM_TIMEOUT != 0) && !bus.mem_ready &&
                (wait_cnt == WAIT_W'(MEM_TIMEOUT - 1));
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        if (bus.mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          nstate   = S_DECODE;
        end else if (timeout) begin
          nstate = S_TRAP;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_R, OP_I, OP_LOAD, OP_STORE, OP_BEQ, OP_JAL: nstate = S_EXEC;
          default:                                       nstate = S_TRAP;
        endcase
      end
      S_EXEC: begin
        case (op_q)
          OP_R:     begin alu_op = 2'b10; nstate = S_WB; end
          OP_I:     begin alu_op = 2'b10; alu_src = 1'b1; nstate = S_WB; end
          OP_LOAD,
          OP_STORE: begin alu_src = 1'b1; nstate = S_MEM; end
          OP_BEQ: begin
            alu_op   = 2'b01;
            branch   = 1'b1;
            pc_write = bus.zero;
            retire   = 1'b1;
            nstate   = S_FETCH;
          end
          OP_JAL:   begin jump = 1'b1; pc_write = 1'b1; nstate = S_WB; end
          default:  nstate = S_TRAP;
        endcase
      end
      S_MEM: begin
        mem_write = (op_q == OP_STORE);
        mem_read  = (op_q != OP_STORE);
        if (bus.mem_ready) begin
          if (op_q == OP_STORE) begin
            retire = 1'b1;
            nstate = S_FETCH;
          end else begin
            nstate = S_WB;
          end
        end else if (timeout) begin
          nstate = S_TRAP;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        mem_2_reg = (op_q == OP_LOAD);
        jump      = (op_q == OP_JAL);
        retire    = 1'b1;
        nstate    = S_FETCH;
      end
      default: begin
        trap = 1'b1;
        busy = 1'b0;
      end
    endcase
  end

  assign bus.pc_write  = pc_write;
  assign bus.ir_write  = ir_write;
  assign bus.alu_op    = alu_op;
  assign bus.alu_src   = alu_src;
  assign bus.mem_read  = mem_read;
  assign bus.mem_write = mem_write;
  assign bus.mem_2_reg = mem_2_reg;
  assign bus.reg_write = reg_write;
  assign bus.branch    = branch;
  assign bus.jump      = jump;
  assign bus.trap      = trap;
  assign bus.busy      = busy;
  assign bus.retired   = retired;

endmodule
